// File: rtl/fb_fill_writer_if.sv
// Avalon-MM burst write bus between the frame-buffer fill writer and the f2h SDRAM
// write port. 64-bit data, 29-bit word address, up to 8-bit burstcount.
//
// Signals:
//   address     word address of the current burst (byte address >> 3)
//   burstcount  beats in the current burst
//   waitrequest slave stall; a beat is accepted when write=1 and waitrequest=0
//   writedata   beat data
//   byteenable  byte lanes written
//   write       write strobe
//
// Modports:
//   master  the fill writer side
//   slave   the SDRAM port / interconnect side
interface fb_fill_writer_if;
  logic [28:0] address;
  logic [7:0]  burstcount;
  logic        waitrequest;
  logic [63:0] writedata;
  logic [7:0]  byteenable;
  logic        write;

  modport master (
    output address,
    output burstcount,
    output writedata,
    output byteenable,
    output write,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  burstcount,
    input  writedata,
    input  byteenable,
    input  write,
    output waitrequest
  );
endinterface

// File: rtl/fb_fill_writer.sv
// Frame-buffer fill writer: Avalon-MM burst write master that paints one whole frame
// buffer in SDRAM with a single 32-bit RGBA colour (screen clear / buffer init).
//
// Parameters:
//   ADDRESS       byte address of frame buffer 0 (multiple of 8)
//   LENGTH        bytes per frame buffer (multiple of 8)
//   BURST_LENGTH  maximum beats per burst, 1..128
//
// Ports:
//   i_clock         system clock
//   i_reset_n       asynchronous active-low reset
//   i_start         single-cycle fill request (ignored while busy or with index 3)
//   i_buffer_index  frame buffer to fill: 0, 1 or 2
//   i_color         fill pixel, sampled together with i_start
//   o_busy          high while a fill is in progress
//   o_done          one-cycle pulse when the last beat has been accepted
//   io_avm          Avalon-MM burst write master bus
module fb_fill_writer #(
  parameter logic [29:0] ADDRESS      = 30'h3800_0000,
  parameter int unsigned LENGTH       = 800 * 480 * 4,
  parameter int unsigned BURST_LENGTH = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic [1:0]             i_buffer_index,
  input  logic [31:0]            i_color,
  output logic                   o_busy,
  output logic                   o_done,
  fb_fill_writer_if.master       io_avm
);

  localparam int unsigned Words  = LENGTH / 8;
  localparam int unsigned WordsW = $clog2(Words + 1);

  typedef enum logic [0:0] {
    StIdle,
    StWrite
  } state_e;

  // Beats in the next burst: the full burst length, or the remaining tail.
  function automatic logic [7:0] burst_for(input logic [WordsW-1:0] words);
    if (32'(words) > BURST_LENGTH) begin
      return 8'(BURST_LENGTH);
    end
    return 8'(words);
  endfunction

  state_e              r_state;
  state_e              w_state_next;
  logic [31:0]         r_color;
  logic [28:0]         r_addr;
  logic [7:0]          r_burstcount;
  logic [WordsW-1:0]   r_words_left;
  logic [WordsW-1:0]   r_beat;
  logic                r_done;

  logic                w_start_ok;
  logic                w_accept;
  logic                w_burst_end;
  logic                w_last_burst;
  logic                w_finish;
  logic [28:0]         w_base;
  logic [WordsW-1:0]   w_words_next;

  // Word address of the selected buffer; the adder wraps silently at 29 bits.
  assign w_base = 29'((32'(ADDRESS) + 32'(i_buffer_index) * LENGTH) >> 3);

  assign w_start_ok   = (r_state == StIdle) && i_start && (i_buffer_index != 2'd3);
  assign w_accept     = (r_state == StWrite) && !io_avm.waitrequest;
  assign w_burst_end  = w_accept && (r_beat == WordsW'(r_burstcount) - WordsW'(1));
  assign w_last_burst = (r_words_left == WordsW'(r_burstcount));
  assign w_finish     = w_burst_end && w_last_burst;
  assign w_words_next = r_words_left - WordsW'(r_burstcount);

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_start_ok) begin
          w_state_next = StWrite;
        end
      end
      StWrite: begin
        if (w_finish) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State-decoded outputs: write is held for the whole fill, including across bursts.
  always_comb begin
    o_busy       = 1'b0;
    io_avm.write = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_busy       = 1'b0;
        io_avm.write = 1'b0;
      end
      StWrite: begin
        o_busy       = 1'b1;
        io_avm.write = 1'b1;
      end
      default: begin
        o_busy       = 1'b0;
        io_avm.write = 1'b0;
      end
    endcase
  end

  // Burst datapath. Everything only moves on start or on an accepted beat, so address,
  // burstcount and writedata are frozen while waitrequest is high.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_color      <= '0;
      r_addr       <= '0;
      r_burstcount <= '0;
      r_words_left <= '0;
      r_beat       <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_start_ok) begin
        r_color      <= i_color;
        r_addr       <= w_base;
        r_words_left <= WordsW'(Words);
        r_burstcount <= burst_for(WordsW'(Words));
        r_beat       <= '0;
      end else if (w_accept) begin
        if (w_burst_end) begin
          r_addr       <= r_addr + 29'(r_burstcount);
          r_words_left <= w_words_next;
          r_burstcount <= burst_for(w_words_next);
          r_beat       <= '0;
        end else begin
          r_beat <= r_beat + WordsW'(1);
        end
      end
    end
  end

  assign o_done            = r_done;
  assign io_avm.address    = r_addr;
  assign io_avm.burstcount = r_burstcount;
  assign io_avm.writedata  = {r_color, r_color};
  assign io_avm.byteenable = 8'hFF;

endmodule

// File: tb/tb_fb_fill_writer.sv
// Bench for fb_fill_writer: a default-parameter instance checked against a table of
// first-burst vectors, and a small instance (LENGTH=320) driven with random waitrequest
// and checked beat-by-beat against an arithmetic model of the expected burst stream.
`timescale 1ns/1ps
module tb_fb_fill_writer;

  localparam int SmLength = 320;
  localparam int SmBurst  = 16;
  localparam int SmWords  = SmLength / 8;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_sm_n, rst_df_n;
  logic        start_sm, start_df;
  logic [1:0]  idx_sm, idx_df;
  logic [31:0] color_sm, color_df;
  logic        busy_sm, done_sm, busy_df, done_df;

  fb_fill_writer_if u_bus_sm ();
  fb_fill_writer_if u_bus_df ();

  fb_fill_writer #(
    .ADDRESS      (30'h0),
    .LENGTH       (SmLength),
    .BURST_LENGTH (SmBurst)
  ) u_dut_sm (
    .i_clock        (clk),
    .i_reset_n      (rst_sm_n),
    .i_start        (start_sm),
    .i_buffer_index (idx_sm),
    .i_color        (color_sm),
    .o_busy         (busy_sm),
    .o_done         (done_sm),
    .io_avm         (u_bus_sm)
  );

  fb_fill_writer u_dut_df (
    .i_clock        (clk),
    .i_reset_n      (rst_df_n),
    .i_start        (start_df),
    .i_buffer_index (idx_df),
    .i_color        (color_df),
    .o_busy         (busy_df),
    .o_done         (done_df),
    .io_avm         (u_bus_df)
  );

  int checks    = 0;
  int failures  = 0;
  int done_count = 0;

  always @(negedge clk) begin
    if (done_sm === 1'b1) done_count <= done_count + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One fill on the small instance. The model says beat n belongs to the burst starting
  // at word (n/16)*16 of the buffer, whose length is min(16, words remaining).
  task automatic run_fill(input logic [1:0] idx, input logic [31:0] color,
                          input int wait_pct, input bit repulse, input int abort_at,
                          input bit skip_start, input bit chain,
                          input logic [1:0] chain_idx, input logic [31:0] chain_color);
    int          n;
    int          cyc;
    int          bstart;
    int          dones_before;
    logic        wreq;
    logic [28:0] base;
    logic [7:0]  exp_bc;
    n = 0;
    cyc = 0;
    base = 29'(idx) * 29'(SmWords);
    dones_before = done_count;
    if (!skip_start) begin
      @(negedge clk);
      start_sm = 1'b1;
      idx_sm   = idx;
      color_sm = color;
      @(negedge clk);
      start_sm = 1'b0;
    end
    while (n < SmWords && cyc < 1000 && !(abort_at >= 0 && n == abort_at)) begin
      bstart = (n / SmBurst) * SmBurst;
      exp_bc = ((SmWords - bstart) < SmBurst) ? 8'(SmWords - bstart) : 8'(SmBurst);
      check("write_during_fill", 64'(u_bus_sm.write), 64'(1'b1));
      check("busy_during_fill", 64'(busy_sm), 64'(1'b1));
      check("done_during_fill", 64'(done_sm), 64'(1'b0));
      check("address", 64'(u_bus_sm.address), 64'(base + 29'(bstart)));
      check("burstcount", 64'(u_bus_sm.burstcount), 64'(exp_bc));
      check("writedata", u_bus_sm.writedata, {color, color});
      check("byteenable", 64'(u_bus_sm.byteenable), 64'(8'hFF));
      wreq = ($urandom_range(99, 0) < 32'(wait_pct));
      u_bus_sm.waitrequest = wreq;
      if (repulse && cyc == 7) begin
        start_sm = 1'b1;
        idx_sm   = 2'(idx + 2'd1);
        color_sm = 32'hFFFF_FFFF;
      end
      if (!wreq) n++;
      @(negedge clk);
      start_sm = 1'b0;
      cyc++;
    end
    if (abort_at < 0) begin
      check("beats_within_budget", 64'(n), 64'(SmWords));
      check("write_after_last", 64'(u_bus_sm.write), 64'(1'b0));
      check("busy_after_last", 64'(busy_sm), 64'(1'b0));
      check("done_after_last", 64'(done_sm), 64'(1'b1));
      u_bus_sm.waitrequest = 1'b0;
      if (chain) begin
        start_sm = 1'b1;
        idx_sm   = chain_idx;
        color_sm = chain_color;
      end
      @(negedge clk);
      start_sm = 1'b0;
      check("done_one_cycle", 64'(done_sm), 64'(1'b0));
      check("done_pulse_count", 64'(done_count - dones_before), 64'(1));
      if (chain) begin
        check("chain_write", 64'(u_bus_sm.write), 64'(1'b1));
        check("chain_address", 64'(u_bus_sm.address), 64'(29'(chain_idx) * 29'(SmWords)));
      end
    end
  endtask

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] color;
    logic        exp_write;
    logic [28:0] exp_addr;
    logic [7:0]  exp_bc;
    logic [63:0] exp_data;
  } dvec_t;

  dvec_t dvec [4];

  initial begin
    logic [1:0]  ridx;
    logic [31:0] rcol;
    int          dones_before;

    dvec[0] = '{2'd0, 32'h1122_3344, 1'b1, 29'h0700_0000, 8'd16, 64'h1122_3344_1122_3344};
    dvec[1] = '{2'd1, 32'hA5A5_0F0F, 1'b1, 29'h0702_EE00, 8'd16, 64'hA5A5_0F0F_A5A5_0F0F};
    dvec[2] = '{2'd2, 32'hDEAD_BEEF, 1'b1, 29'h0705_DC00, 8'd16, 64'hDEAD_BEEF_DEAD_BEEF};
    dvec[3] = '{2'd3, 32'h1234_5678, 1'b0, 29'h0,         8'd0,  64'h0};

    rst_sm_n = 1'b1;
    rst_df_n = 1'b1;
    start_sm = 1'b0;
    start_df = 1'b0;
    idx_sm   = 2'd0;
    idx_df   = 2'd0;
    color_sm = 32'h0;
    color_df = 32'h0;
    u_bus_sm.waitrequest = 1'b0;
    u_bus_df.waitrequest = 1'b0;
    #1;
    rst_sm_n = 1'b0;
    rst_df_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_busy", 64'(busy_sm), 64'(1'b0));
    check("rst_done", 64'(done_sm), 64'(1'b0));
    check("rst_write", 64'(u_bus_sm.write), 64'(1'b0));
    check("rst_address", 64'(u_bus_sm.address), 64'(0));
    check("rst_burstcount", 64'(u_bus_sm.burstcount), 64'(0));
    check("rst_writedata", u_bus_sm.writedata, 64'h0);
    check("rst_byteenable", 64'(u_bus_sm.byteenable), 64'(8'hFF));
    rst_sm_n = 1'b1;
    rst_df_n = 1'b1;

    // Default-parameter instance: first burst of each buffer, then one burst later.
    for (int i = 0; i < 4; i++) begin
      rst_df_n = 1'b0;
      @(negedge clk);
      rst_df_n = 1'b1;
      @(negedge clk);
      start_df = 1'b1;
      idx_df   = dvec[i].idx;
      color_df = dvec[i].color;
      @(negedge clk);
      start_df = 1'b0;
      check("df_write", 64'(u_bus_df.write), 64'(dvec[i].exp_write));
      check("df_busy", 64'(busy_df), 64'(dvec[i].exp_write));
      check("df_done", 64'(done_df), 64'(1'b0));
      check("df_address", 64'(u_bus_df.address), 64'(dvec[i].exp_addr));
      check("df_burstcount", 64'(u_bus_df.burstcount), 64'(dvec[i].exp_bc));
      check("df_writedata", u_bus_df.writedata, dvec[i].exp_data);
      repeat (16) @(negedge clk);
      check("df_second_address", 64'(u_bus_df.address),
            64'(dvec[i].exp_write ? dvec[i].exp_addr + 29'd16 : 29'd0));
      check("df_second_burstcount", 64'(u_bus_df.burstcount), 64'(dvec[i].exp_bc));
      check("df_still_writing", 64'(u_bus_df.write), 64'(dvec[i].exp_write));
    end

    // Small instance: index 3 is ignored.
    dones_before = done_count;
    @(negedge clk);
    start_sm = 1'b1;
    idx_sm   = 2'd3;
    color_sm = 32'hCAFE_F00D;
    @(negedge clk);
    start_sm = 1'b0;
    repeat (4) begin
      check("idx3_write", 64'(u_bus_sm.write), 64'(1'b0));
      check("idx3_busy", 64'(busy_sm), 64'(1'b0));
      @(negedge clk);
    end
    check("idx3_no_done", 64'(done_count - dones_before), 64'(0));

    // Directed fill: bursts 0/16/32 with counts 16/16/8; then a start in the done cycle.
    run_fill(2'd0, 32'h1122_3344, 0, 1'b0, -1, 1'b0, 1'b1, 2'd1, 32'h5566_7788);
    run_fill(2'd1, 32'h5566_7788, 0, 1'b0, -1, 1'b1, 1'b0, 2'd0, 32'h0);

    // Start re-pulsed mid-fill with white is ignored.
    run_fill(2'd2, 32'h0A0B_0C0D, 0, 1'b1, -1, 1'b0, 1'b0, 2'd0, 32'h0);
    run_fill(2'd0, 32'h0102_0304, 50, 1'b1, -1, 1'b0, 1'b0, 2'd0, 32'h0);

    // Random colours/buffers under 50% waitrequest.
    for (int k = 0; k < 4; k++) begin
      ridx = 2'($urandom_range(2, 0));
      rcol = $urandom;
      run_fill(ridx, rcol, 50, 1'b0, -1, 1'b0, 1'b0, 2'd0, 32'h0);
    end

    // Reset after 5 beats: write/busy drop at once, no done, restart begins at base.
    dones_before = done_count;
    run_fill(2'd1, 32'h7777_8888, 0, 1'b0, 5, 1'b0, 1'b0, 2'd0, 32'h0);
    rst_sm_n = 1'b0;
    #1;
    check("abort_write", 64'(u_bus_sm.write), 64'(1'b0));
    check("abort_busy", 64'(busy_sm), 64'(1'b0));
    repeat (3) @(negedge clk);
    check("abort_no_done", 64'(done_count - dones_before), 64'(0));
    rst_sm_n = 1'b1;
    run_fill(2'd1, 32'h9999_AAAA, 30, 1'b0, -1, 1'b0, 1'b0, 2'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
